// File: rtl/hm_tx.sv
// Host-memory read initiator: splits a DW-aligned host region into MRd TLPs on the
// 64-bit TRN transmit interface, one outstanding request at a time.
module hm_tx #(
    parameter int unsigned MAX_RD_DW = 128,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  logic        trn_clk,
    input  logic        trn_reset_n,
    input  logic        trn_lnk_up_n,
    input  logic        hm_start,
    input  logic [63:0] hm_addr,
    input  logic [10:0] hm_len,
    input  logic [15:0] cfg_requester_id,
    input  logic        rx_memory_read,
    output logic [63:0] trn_td,
    output logic        trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    input  logic        trn_tdst_rdy_n,
    input  logic        trn_tdst_dsc_n,
    input  logic [5:0]  trn_tbuf_av,
    output logic        hm_busy,
    output logic        hm_done,
    output logic        hm_timeout,
    output logic [31:0] stat_trn_cpt_tx,
    output logic [2:0]  stat_state
);

    localparam int unsigned LEN_W  = 11;
    localparam int unsigned ADDR_W = 62;
    localparam int unsigned TMO_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_HDR  = 3'd2,
        S_ADDR = 3'd3,
        S_WAIT = 3'd4
    } state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   rem_q;
    logic [LEN_W-1:0]   chunk_q;
    logic               is4dw_q;
    logic [4:0]         tag_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [63:0]        td_q;
    logic               trem_n_q;
    logic               tsof_n_q;
    logic               teof_n_q;
    logic               tsrc_rdy_n_q;
    logic               busy_q;
    logic               done_q;
    logic               timeout_q;
    logic [31:0]        stat_q;

    logic [LEN_W-1:0]   len_c;
    logic [LEN_W-1:0]   to4k_c;
    logic [LEN_W-1:0]   max_c;
    logic [LEN_W-1:0]   min1_c;
    logic [LEN_W-1:0]   chunk_c;
    logic [3:0]         last_be_c;
    logic [63:0]        qw0_c;
    logic [63:0]        qw1_c;
    logic [ADDR_W-1:0]  addr_d;
    logic [LEN_W-1:0]   rem_d;
    logic [TMO_W-1:0]   tmo_d;
    logic               unused_c;

    // Request sizing: bounded by remaining length, max read size and the next 4 KB page.
    assign len_c   = (hm_len == 11'd0 || hm_len >= 11'd1024) ? 11'd1024 : hm_len;
    assign to4k_c  = 11'd1024 - {1'b0, addr_q[9:0]};
    assign max_c   = LEN_W'(MAX_RD_DW);
    assign min1_c  = (rem_q < max_c) ? rem_q : max_c;
    assign chunk_c = (min1_c < to4k_c) ? min1_c : to4k_c;

    assign last_be_c = (chunk_q > 11'd1) ? 4'hF : 4'h0;
    assign qw0_c = {1'b0, (is4dw_q ? 2'b01 : 2'b00), 5'b00000, 1'b0, 3'b000, 4'b0000,
                    1'b0, 1'b0, 2'b00, 2'b00, chunk_q[9:0],
                    cfg_requester_id, 3'b000, tag_q, last_be_c, 4'hF};
    assign qw1_c = is4dw_q ? {addr_q[61:30], addr_q[29:0], 2'b00}
                           : {addr_q[29:0], 2'b00, 32'h0000_0000};

    assign addr_d = addr_q + ADDR_W'(chunk_q);
    assign rem_d  = rem_q - chunk_q;
    assign tmo_d  = tmo_q + TMO_W'(1);

    assign unused_c = ^{hm_addr[1:0], trn_tbuf_av[5:2], trn_tbuf_av[0]};

    always_ff @(posedge trn_clk) begin
        if (!trn_reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            chunk_q      <= '0;
            is4dw_q      <= 1'b0;
            tag_q        <= '0;
            tmo_q        <= '0;
            td_q         <= '0;
            trem_n_q     <= 1'b1;
            tsof_n_q     <= 1'b1;
            teof_n_q     <= 1'b1;
            tsrc_rdy_n_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            stat_q       <= '0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (state_q != S_IDLE && trn_lnk_up_n) begin
                // Link lost mid-operation: abandon the frame and report as a timeout.
                state_q      <= S_IDLE;
                tsrc_rdy_n_q <= 1'b1;
                tsof_n_q     <= 1'b1;
                teof_n_q     <= 1'b1;
                timeout_q    <= 1'b1;
                busy_q       <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (hm_start && !trn_lnk_up_n) begin
                            addr_q  <= hm_addr[63:2];
                            rem_q   <= len_c;
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_CALC: begin
                        chunk_q <= chunk_c;
                        is4dw_q <= (addr_q[61:30] != 32'h0);
                        state_q <= S_HDR;
                    end
                    S_HDR: begin
                        if (!trn_tdst_dsc_n) begin
                            tsrc_rdy_n_q <= 1'b1;
                            tsof_n_q     <= 1'b1;
                        end else if (!tsrc_rdy_n_q) begin
                            if (!trn_tdst_rdy_n) begin
                                td_q     <= qw1_c;
                                trem_n_q <= !is4dw_q;
                                tsof_n_q <= 1'b1;
                                teof_n_q <= 1'b0;
                                state_q  <= S_ADDR;
                            end
                        end else if (trn_tbuf_av[1]) begin
                            td_q         <= qw0_c;
                            trem_n_q     <= 1'b0;
                            tsof_n_q     <= 1'b0;
                            teof_n_q     <= 1'b1;
                            tsrc_rdy_n_q <= 1'b0;
                        end
                    end
                    S_ADDR: begin
                        if (!trn_tdst_dsc_n) begin
                            tsrc_rdy_n_q <= 1'b1;
                            tsof_n_q     <= 1'b1;
                            teof_n_q     <= 1'b1;
                            state_q      <= S_HDR;
                        end else if (!trn_tdst_rdy_n) begin
                            tsrc_rdy_n_q <= 1'b1;
                            teof_n_q     <= 1'b1;
                            tag_q        <= tag_q + 5'd1;
                            stat_q       <= stat_q + 32'd1;
                            addr_q       <= addr_d;
                            rem_q        <= rem_d;
                            tmo_q        <= '0;
                            state_q      <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        // Completion arrival takes priority over a coincident expiry.
                        if (rx_memory_read) begin
                            if (rem_q == 11'd0) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_CALC;
                            end
                        end else if (tmo_d == TIMEOUT) begin
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            tmo_q <= tmo_d;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign trn_td          = td_q;
    assign trn_trem_n      = trem_n_q;
    assign trn_tsof_n      = tsof_n_q;
    assign trn_teof_n      = teof_n_q;
    assign trn_tsrc_rdy_n  = tsrc_rdy_n_q;
    assign trn_tsrc_dsc_n  = 1'b1;
    assign hm_busy         = busy_q;
    assign hm_done         = done_q;
    assign hm_timeout      = timeout_q;
    assign stat_trn_cpt_tx = stat_q;
    assign stat_state      = state_q;

endmodule

// File: tb/tb_hm_tx.sv
// Directed self-checking bench for hm_tx: header encoding, splitting, flow control,
// discontinue, timeout, link loss and reset.
module tb_hm_tx;

    logic        trn_clk = 1'b0;
    logic        trn_reset_n;
    logic        trn_lnk_up_n;
    logic        hm_start;
    logic [63:0] hm_addr;
    logic [10:0] hm_len;
    logic [15:0] cfg_requester_id;
    logic        rx_memory_read;
    logic [63:0] trn_td;
    logic        trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n;
    logic        trn_tdst_dsc_n;
    logic [5:0]  trn_tbuf_av;
    logic        hm_busy;
    logic        hm_done;
    logic        hm_timeout;
    logic [31:0] stat_trn_cpt_tx;
    logic [2:0]  stat_state;

    int n_pass  = 0;
    int n_total = 0;

    hm_tx #(.MAX_RD_DW(128), .TIMEOUT(16'd100)) dut (
        .trn_clk          (trn_clk),
        .trn_reset_n      (trn_reset_n),
        .trn_lnk_up_n     (trn_lnk_up_n),
        .hm_start         (hm_start),
        .hm_addr          (hm_addr),
        .hm_len           (hm_len),
        .cfg_requester_id (cfg_requester_id),
        .rx_memory_read   (rx_memory_read),
        .trn_td           (trn_td),
        .trn_trem_n       (trn_trem_n),
        .trn_tsof_n       (trn_tsof_n),
        .trn_teof_n       (trn_teof_n),
        .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n   (trn_tsrc_dsc_n),
        .trn_tdst_rdy_n   (trn_tdst_rdy_n),
        .trn_tdst_dsc_n   (trn_tdst_dsc_n),
        .trn_tbuf_av      (trn_tbuf_av),
        .hm_busy          (hm_busy),
        .hm_done          (hm_done),
        .hm_timeout       (hm_timeout),
        .stat_trn_cpt_tx  (stat_trn_cpt_tx),
        .stat_state       (stat_state)
    );

    always #5 trn_clk = ~trn_clk;

    task automatic tick();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    task automatic do_reset();
        trn_reset_n    = 1'b0;
        hm_start       = 1'b0;
        rx_memory_read = 1'b0;
        tick();
        tick();
        trn_reset_n = 1'b1;
    endtask

    task automatic start(input logic [63:0] a, input logic [10:0] l);
        hm_addr  = a;
        hm_len   = l;
        hm_start = 1'b1;
        tick();
        hm_start = 1'b0;
    endtask

    task automatic rx_pulse();
        rx_memory_read = 1'b1;
        tick();
        rx_memory_read = 1'b0;
    endtask

    // Waits (bounded) for a valid beat, checks it, and lets it transfer on the next edge.
    task automatic expect_beat(input string name, input logic [63:0] td,
                               input logic sof_n, input logic eof_n, input logic trem_n);
        int n = 0;
        while (trn_tsrc_rdy_n && n < 50) begin
            tick();
            n++;
        end
        check({name, "_vld"}, 64'(trn_tsrc_rdy_n), 64'(1'b0));
        check({name, "_td"}, trn_td, td);
        check({name, "_ctl"}, 64'({trn_tsof_n, trn_teof_n, trn_trem_n}),
              64'({sof_n, eof_n, trem_n}));
        tick();
    endtask

    initial begin
        trn_lnk_up_n     = 1'b0;
        hm_addr          = '0;
        hm_len           = '0;
        cfg_requester_id = 16'h0100;
        trn_tdst_rdy_n   = 1'b0;
        trn_tdst_dsc_n   = 1'b1;
        trn_tbuf_av      = 6'h3F;

        // 1: reset values, then a single 3DW request
        do_reset();
        check("rst_td", trn_td, 64'h0);
        check("rst_ctl", 64'({trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n}),
              64'(5'b11111));
        check("rst_flags", 64'({hm_busy, hm_done, hm_timeout}), 64'(3'b000));
        check("rst_stat", 64'(stat_trn_cpt_tx), 64'h0);
        check("rst_state", 64'(stat_state), 64'h0);
        start(64'h1000_0000, 11'd4);
        check("t1_busy", 64'(hm_busy), 64'h1);
        check("t1_calc", 64'(stat_state), 64'h1);
        expect_beat("t1_qw0", 64'h00000004_010000FF, 1'b0, 1'b1, 1'b0);
        expect_beat("t1_qw1", 64'h10000000_00000000, 1'b1, 1'b0, 1'b1);
        check("t1_wait", 64'(stat_state), 64'h4);
        rx_pulse();
        check("t1_done", 64'(hm_done), 64'h1);
        check("t1_stat", 64'(stat_trn_cpt_tx), 64'h1);
        tick();
        check("t1_done_pulse", 64'({hm_done, hm_busy}), 64'h0);

        // 2: 4DW request of one DW
        do_reset();
        start(64'h1_0000_0000, 11'd1);
        expect_beat("t2_qw0", 64'h20000001_0100000F, 1'b0, 1'b1, 1'b0);
        expect_beat("t2_qw1", 64'h00000001_00000000, 1'b1, 1'b0, 1'b0);
        rx_pulse();
        check("t2_done", 64'(hm_done), 64'h1);

        // 3: 4 KB split into two requests
        do_reset();
        start(64'h0000_0FF0, 11'd8);
        expect_beat("t3a_qw0", 64'h00000004_010000FF, 1'b0, 1'b1, 1'b0);
        expect_beat("t3a_qw1", 64'h00000FF0_00000000, 1'b1, 1'b0, 1'b1);
        repeat (5) tick();
        check("t3_hold", 64'({trn_tsrc_rdy_n, stat_state}), 64'({1'b1, 3'd4}));
        rx_pulse();
        check("t3_nodone", 64'(hm_done), 64'h0);
        expect_beat("t3b_qw0", 64'h00000004_010001FF, 1'b0, 1'b1, 1'b0);
        expect_beat("t3b_qw1", 64'h00001000_00000000, 1'b1, 1'b0, 1'b1);
        rx_pulse();
        check("t3_done", 64'(hm_done), 64'h1);

        // 4: length 0 means 1024 DW, split by MAX_RD_DW into 8 requests
        do_reset();
        start(64'h2000_0000, 11'd0);
        for (int i = 0; i < 8; i++) begin
            expect_beat($sformatf("t4_%0d_qw0", i),
                        {32'h00000080, 16'h0100, 3'b000, 5'(i), 8'hFF}, 1'b0, 1'b1, 1'b0);
            expect_beat($sformatf("t4_%0d_qw1", i),
                        {32'h2000_0000 + 32'(i * 512), 32'h0}, 1'b1, 1'b0, 1'b1);
            rx_pulse();
            check($sformatf("t4_%0d_done", i), 64'(hm_done), 64'(i == 7));
        end
        check("t4_stat", 64'(stat_trn_cpt_tx), 64'd8);

        // 5: buffer/destination backpressure, then discontinue in ADDR
        do_reset();
        trn_tdst_rdy_n = 1'b1;
        trn_tbuf_av    = 6'h00;
        start(64'h1000_0000, 11'd4);
        tick();
        tick();
        check("t5_nobuf0", 64'(trn_tsrc_rdy_n), 64'h1);
        tick();
        check("t5_nobuf1", 64'(trn_tsrc_rdy_n), 64'h1);
        trn_tbuf_av = 6'h02;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5_stall%0d", i),
                  {trn_td[63:4], trn_tsof_n, trn_tsrc_rdy_n, 2'b00},
                  {64'h00000004_010000FF} & 64'hFFFF_FFFF_FFFF_FFF0);
            tick();
        end
        trn_tdst_rdy_n = 1'b0;
        tick();
        check("t5_qw1", trn_td, 64'h10000000_00000000);
        check("t5_eof", 64'({trn_teof_n, trn_tsrc_rdy_n}), 64'h0);
        trn_tdst_rdy_n = 1'b1;
        trn_tdst_dsc_n = 1'b0;
        tick();
        check("t5_dsc", 64'({trn_tsrc_rdy_n, stat_state}), 64'({1'b1, 3'd2}));
        trn_tdst_dsc_n = 1'b1;
        trn_tdst_rdy_n = 1'b0;
        expect_beat("t5_rs_qw0", 64'h00000004_010000FF, 1'b0, 1'b1, 1'b0);
        expect_beat("t5_rs_qw1", 64'h10000000_00000000, 1'b1, 1'b0, 1'b1);
        check("t5_stat", 64'(stat_trn_cpt_tx), 64'h1);
        rx_pulse();
        check("t5_done", 64'(hm_done), 64'h1);

        // 6: no completion -> timeout 100 cycles after EOF
        start(64'h1000_0000, 11'd4);
        expect_beat("t6_qw0", 64'h00000004_010001FF, 1'b0, 1'b1, 1'b0);
        expect_beat("t6_qw1", 64'h10000000_00000000, 1'b1, 1'b0, 1'b1);
        repeat (99) tick();
        check("t6_early", 64'({hm_timeout, stat_state}), 64'({1'b0, 3'd4}));
        tick();
        check("t6_tmo", 64'({hm_timeout, hm_busy, stat_state}), 64'({1'b1, 1'b0, 3'd0}));
        tick();
        check("t6_pulse", 64'(hm_timeout), 64'h0);

        // 7: link loss while stalled in HDR, start ignored while link down
        trn_tbuf_av = 6'h00;
        start(64'h1000_0000, 11'd4);
        tick();
        check("t7_busy", 64'(hm_busy), 64'h1);
        trn_lnk_up_n = 1'b1;
        tick();
        check("t7_lnk", 64'({hm_timeout, trn_tsrc_rdy_n, stat_state}), 64'({1'b1, 1'b1, 3'd0}));
        start(64'h1000_0000, 11'd4);
        check("t7_ign", 64'({hm_busy, stat_state}), 64'h0);
        trn_lnk_up_n = 1'b0;
        trn_tbuf_av  = 6'h02;

        // 8: reset while the address beat is presented
        start(64'h1000_0000, 11'd4);
        expect_beat("t8_qw0", 64'h00000004_010002FF, 1'b0, 1'b1, 1'b0);
        check("t8_inaddr", 64'({trn_teof_n, stat_state}), 64'({1'b0, 3'd3}));
        trn_reset_n = 1'b0;
        tick();
        trn_reset_n = 1'b1;
        check("t8_td", trn_td, 64'h0);
        check("t8_ctl", 64'({trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n}), 64'(4'b1111));
        check("t8_state", 64'({hm_busy, stat_state, stat_trn_cpt_tx}), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
